// File: rtl/phase_seq_pkg.sv
// Shared types, constants and the phase-walk helper for the phase sequencer.
package phase_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_RUN     = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_DONE    = 3'd4,
    ST_FAULT   = 3'd5
  } seq_state_e;

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

  localparam int unsigned WDOG_MAX_DEFAULT = 1024;
  localparam int unsigned WDOG_W           = 16;

  typedef struct packed {
    logic       wrap;
    logic [1:0] idx;
  } next_phase_t;

  // Lowest set mask bit above cur; if none, wrap to the lowest set bit.
  // Calling with cur = PH3 therefore yields the first phase of a pass.
  function automatic next_phase_t next_phase(input logic [3:0] mask,
                                             input logic [1:0] cur);
    next_phase_t res;
    res.wrap = 1'b1;
    res.idx  = PH0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) begin
        res.idx = 2'(i);
      end
    end
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        res.idx  = 2'(i);
        res.wrap = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase watchdog: counts enabled cycles and flags the cycle in which the
// running total reaches WDOG_MAX.
module phase_watchdog
  import phase_seq_pkg::*;
#(
  parameter int unsigned WDOG_MAX = WDOG_MAX_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [WDOG_W-1:0] LIMIT   = WDOG_W'(WDOG_MAX);
  localparam logic [WDOG_W-1:0] CNT_TOP = {WDOG_W{1'b1}};

  logic [WDOG_W-1:0] cnt_q;
  logic [WDOG_W-1:0] cnt_d;

  // Count saturates so a stuck enable can never wrap back below the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {WDOG_W{1'b0}};
    end else if (en_i && (cnt_q != CNT_TOP)) begin
      cnt_d = cnt_q + {{(WDOG_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {WDOG_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The enabled cycle that brings the total to LIMIT is the expiring one.
  assign expired_o = en_i && (cnt_q >= (LIMIT - {{(WDOG_W-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/phase_sequencer.sv
// Sequences the multi-phase timer through its masked phases, with repeat,
// pause, abort and a per-phase watchdog. All outputs are registered.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int unsigned WDOG_MAX = WDOG_MAX_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       run_req_i,
  input  logic       abort_i,
  input  logic       pause_i,
  input  logic [3:0] phase_mask_i,
  input  logic [7:0] repeat_cnt_i,
  input  logic       timer_done_i,
  output logic [1:0] timer_phase_sel_o,
  output logic       timer_start_o,
  output logic       timer_enable_o,
  output logic [1:0] cur_phase_o,
  output logic [7:0] passes_done_o,
  output logic       busy_o,
  output logic       seq_done_o,
  output logic       fault_o,
  output logic       cfg_err_o
);

  seq_state_e  state_q;
  logic [3:0]  mask_q;
  logic [7:0]  rep_q;
  logic [1:0]  phase_q;
  logic [7:0]  passes_q;
  logic        start_q;
  logic        enable_q;
  logic        busy_q;
  logic        seq_done_q;
  logic        fault_q;
  logic        cfg_err_q;

  next_phase_t adv_d;
  logic [7:0]  passes_inc_d;
  logic        finish_d;
  logic        wd_clear;
  logic        wd_expired;

  // Decision taken in ADVANCE: where to go next and whether the run is over.
  always_comb begin
    adv_d        = next_phase(mask_q, phase_q);
    passes_inc_d = passes_q + 8'd1;
    if (adv_d.wrap && (rep_q != 8'd0) && (passes_inc_d == rep_q)) begin
      finish_d = 1'b1;
    end else begin
      finish_d = 1'b0;
    end
  end

  assign wd_clear = (state_q != ST_RUN);

  phase_watchdog #(
    .WDOG_MAX (WDOG_MAX)
  ) u_wdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (wd_clear),
    .en_i      (enable_q),
    .expired_o (wd_expired)
  );

  // Main FSM; every output register is loaded alongside its state transition.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      mask_q     <= 4'd0;
      rep_q      <= 8'd0;
      phase_q    <= PH0;
      passes_q   <= 8'd0;
      start_q    <= 1'b0;
      enable_q   <= 1'b0;
      busy_q     <= 1'b0;
      seq_done_q <= 1'b0;
      fault_q    <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      start_q    <= 1'b0;
      enable_q   <= 1'b0;
      seq_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      if (abort_i && (state_q != ST_FAULT)) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_FAULT: begin
            if (run_req_i) begin
              fault_q <= 1'b0;
              if (phase_mask_i != 4'd0) begin
                mask_q   <= phase_mask_i;
                rep_q    <= repeat_cnt_i;
                passes_q <= 8'd0;
                phase_q  <= next_phase(phase_mask_i, PH3).idx;
                state_q  <= ST_ARM;
                start_q  <= 1'b1;
                busy_q   <= 1'b1;
              end else begin
                cfg_err_q <= 1'b1;
                state_q   <= ST_IDLE;
                busy_q    <= 1'b0;
              end
            end else begin
              state_q <= state_q;
              busy_q  <= 1'b0;
            end
          end
          ST_ARM: begin
            state_q  <= ST_RUN;
            enable_q <= !pause_i;
          end
          ST_RUN: begin
            // A done in the same cycle as expiry still completes the phase.
            if (timer_done_i) begin
              state_q <= ST_ADVANCE;
            end else if (wd_expired) begin
              state_q <= ST_FAULT;
              fault_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              enable_q <= !pause_i;
            end
          end
          ST_ADVANCE: begin
            if (adv_d.wrap) begin
              passes_q <= passes_inc_d;
            end else begin
              passes_q <= passes_q;
            end
            if (finish_d) begin
              state_q    <= ST_DONE;
              seq_done_q <= 1'b1;
            end else begin
              phase_q <= adv_d.idx;
              state_q <= ST_ARM;
              start_q <= 1'b1;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign timer_phase_sel_o = phase_q;
  assign cur_phase_o       = phase_q;
  assign timer_start_o     = start_q;
  assign timer_enable_o    = enable_q;
  assign passes_done_o     = passes_q;
  assign busy_o            = busy_q;
  assign seq_done_o        = seq_done_q;
  assign fault_o           = fault_q;
  assign cfg_err_o         = cfg_err_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: vector table, directed corner cases
// and randomized runs against a pass/phase-list reference model.
module tb_phase_sequencer;

  localparam int unsigned WD = 16;

  logic       clk = 1'b0;
  logic       rst, run_req, abort, pause, timer_done;
  logic [3:0] phase_mask;
  logic [7:0] repeat_cnt;
  logic [1:0] timer_phase_sel, cur_phase;
  logic       timer_start, timer_enable, busy, seq_done, fault, cfg_err;
  logic [7:0] passes_done;

  always #5 clk = ~clk;

  phase_sequencer #(.WDOG_MAX(WD)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .run_req_i         (run_req),
    .abort_i           (abort),
    .pause_i           (pause),
    .phase_mask_i      (phase_mask),
    .repeat_cnt_i      (repeat_cnt),
    .timer_done_i      (timer_done),
    .timer_phase_sel_o (timer_phase_sel),
    .timer_start_o     (timer_start),
    .timer_enable_o    (timer_enable),
    .cur_phase_o       (cur_phase),
    .passes_done_o     (passes_done),
    .busy_o            (busy),
    .seq_done_o        (seq_done),
    .fault_o           (fault),
    .cfg_err_o         (cfg_err)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          starts, seq_dones, cfg_errs, tcnt, done_cyc, seq_cyc, dly;
  bit          done_auto;
  logic [31:0] ph_code;

  typedef struct {
    logic [3:0] mask;
    logic [7:0] rep;
    int         exp_starts;
    int         exp_passes;
    int         exp_cfg;
    int         exp_seq;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One clock: observe outputs at the falling edge, then drive the timer model.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (timer_start) begin
      starts++;
      ph_code = (ph_code << 2) | 32'(timer_phase_sel);
      tcnt = 0;
    end
    if (timer_enable) tcnt++;
    if (seq_done) begin
      seq_dones++;
      seq_cyc = cyc;
    end
    if (cfg_err) cfg_errs++;
    timer_done = done_auto && timer_enable && (tcnt == dly);
    if (timer_done) done_cyc = cyc;
  endtask

  task automatic start_run(input logic [3:0] mask, input logic [7:0] rep);
    phase_mask = mask;
    repeat_cnt = rep;
    starts = 0; seq_dones = 0; cfg_errs = 0; ph_code = 0; tcnt = 0;
    seq_cyc = -1; done_cyc = -1;
    run_req = 1'b1;
    step();
    run_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rnd_pause, output int idle_at);
    int k;
    k = 0;
    idle_at = -1;
    while (busy && (k < budget)) begin
      pause = rnd_pause ? ($urandom_range(0, 9) == 0) : 1'b0;
      step();
      k++;
    end
    pause = 1'b0;
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles, want 0", budget);
    end else begin
      idle_at = cyc;
    end
  endtask

  // Reference: a run visits every set mask bit in ascending order, rep times.
  function automatic logic [31:0] model_code(input logic [3:0] mask, input int rep);
    logic [31:0] c;
    c = 32'd0;
    for (int p = 0; p < rep; p++)
      for (int i = 0; i < 4; i++)
        if (mask[i]) c = (c << 2) | 32'(i);
    return c;
  endfunction

  initial begin
    vec_t vecs[5];
    int   idle_at, k, low_cnt, s0;
    logic prev_en;
    logic [3:0] rm;
    int   rr;

    vecs[0] = '{4'b1111, 8'd1, 4, 1, 0, 1};
    vecs[1] = '{4'b1010, 8'd3, 6, 3, 0, 1};
    vecs[2] = '{4'b0100, 8'd2, 2, 2, 0, 1};
    vecs[3] = '{4'b0000, 8'd1, 0, 2, 1, 0};
    vecs[4] = '{4'b1001, 8'd2, 4, 2, 0, 1};

    rst = 1'b1; run_req = 1'b0; abort = 1'b0; pause = 1'b0; timer_done = 1'b0;
    phase_mask = 4'd0; repeat_cnt = 8'd0; done_auto = 1'b0; dly = 5;
    starts = 0; seq_dones = 0; cfg_errs = 0; tcnt = 0; ph_code = 0;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_start", timer_start, 0);
    check("rst_enable", timer_enable, 0);
    check("rst_fault", fault, 0);
    check("rst_seq_done", seq_done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_phase_sel", timer_phase_sel, 0);
    check("rst_cur_phase", cur_phase, 0);
    check("rst_passes", passes_done, 0);
    rst = 1'b0;
    step();

    // Full sequence with latency checks
    done_auto = 1'b1; dly = 5;
    start_run(4'b1111, 8'd1);
    check("lat_start_t1", timer_start, 1);
    check("lat_busy_t1", busy, 1);
    check("lat_enable_t1", timer_enable, 0);
    step();
    check("lat_enable_t2", timer_enable, 1);
    check("lat_start_t2", timer_start, 0);
    wait_idle(300, 1'b0, idle_at);
    check("full_phases", ph_code, model_code(4'b1111, 1));
    check("full_starts", starts, 4);
    check("full_seq_after_done", seq_cyc - done_cyc, 2);
    check("full_idle_after_seq", idle_at - seq_cyc, 1);
    check("full_passes", passes_done, 1);

    // Vector table
    for (int v = 0; v < 5; v++) begin
      dly = 3;
      start_run(vecs[v].mask, vecs[v].rep);
      wait_idle(400, 1'b0, idle_at);
      step(); step();
      check("vec_starts", starts, vecs[v].exp_starts);
      check("vec_passes", passes_done, vecs[v].exp_passes);
      check("vec_cfg_err", cfg_errs, vecs[v].exp_cfg);
      check("vec_seq_done", seq_dones, vecs[v].exp_seq);
      check("vec_phases", ph_code, model_code(vecs[v].mask, (vecs[v].exp_cfg != 0) ? 0 : int'(vecs[v].rep)));
      check("vec_busy", busy, 0);
    end

    // Pause: 10 paused cycles, enable low, watchdog frozen (12 enabled < 16)
    dly = 12;
    start_run(4'b0001, 8'd1);
    step();
    low_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      pause = 1'b1;
      step();
      if (!timer_enable) low_cnt++;
    end
    pause = 1'b0;
    check("pause_enable_low", low_cnt, 10);
    wait_idle(200, 1'b0, idle_at);
    check("pause_no_fault", fault, 0);
    check("pause_seq_done", seq_dones, 1);
    check("pause_starts", starts, 1);

    // Watchdog expiry
    done_auto = 1'b0;
    start_run(4'b1111, 8'd1);
    prev_en = 1'b0; k = 0;
    while (!fault && (k < 100)) begin
      prev_en = timer_enable;
      step();
      k++;
    end
    check("wdog_fault", fault, 1);
    check("wdog_enabled_cycles", tcnt, WD);
    check("wdog_prev_enable", prev_en, 1);
    check("wdog_busy", busy, 0);
    check("wdog_enable", timer_enable, 0);
    step(); step(); step();
    check("wdog_sticky", fault, 1);
    done_auto = 1'b1; dly = 3;
    start_run(4'b1111, 8'd1);
    check("wdog_clr_fault", fault, 0);
    check("wdog_restart_start", timer_start, 1);
    check("wdog_restart_phase", timer_phase_sel, 0);
    wait_idle(300, 1'b0, idle_at);
    check("wdog_restart_seq", seq_dones, 1);

    // Done on the same cycle the watchdog would expire
    dly = WD;
    start_run(4'b0001, 8'd1);
    wait_idle(200, 1'b0, idle_at);
    check("wd_done_tie_fault", fault, 0);
    check("wd_done_tie_seq", seq_dones, 1);

    // Abort colliding with timer_done
    dly = 5;
    start_run(4'b1111, 8'd1);
    k = 0;
    while (!timer_done && (k < 50)) begin
      step();
      k++;
    end
    check("abort_saw_done", timer_done, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_enable", timer_enable, 0);
    s0 = starts;
    step(); step(); step(); step();
    check("abort_no_advance", starts, s0);
    check("abort_no_seq", seq_dones, 0);
    check("abort_passes", passes_done, 0);

    // Continuous mode, aborted after the 6th start
    dly = 2;
    start_run(4'b0001, 8'd0);
    k = 0;
    while ((starts < 6) && (k < 300)) begin
      step();
      k++;
    end
    check("cont_starts", starts, 6);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("cont_passes_hold", passes_done, 5);
    check("cont_busy", busy, 0);
    check("cont_no_seq", seq_dones, 0);

    // run_req while busy is ignored, mid-run config changes have no effect
    dly = 3;
    start_run(4'b0011, 8'd1);
    step(); step();
    phase_mask = 4'b1111; repeat_cnt = 8'd5; run_req = 1'b1;
    step();
    run_req = 1'b0;
    wait_idle(300, 1'b0, idle_at);
    check("busy_req_phases", ph_code, model_code(4'b0011, 1));
    check("busy_req_starts", starts, 2);
    check("busy_req_passes", passes_done, 1);
    check("busy_req_seq", seq_dones, 1);

    // Reset mid-run
    dly = 5;
    start_run(4'b1111, 8'd1);
    for (int i = 0; i < 8; i++) step();
    check("midrst_pre_phase", timer_phase_sel, 1);
    rst = 1'b1;
    step();
    check("midrst_busy", busy, 0);
    check("midrst_enable", timer_enable, 0);
    check("midrst_phase", timer_phase_sel, 0);
    check("midrst_passes", passes_done, 0);
    rst = 1'b0;
    step();

    // Randomized runs with random pause
    for (int r = 0; r < 25; r++) begin
      rm  = 4'($urandom_range(1, 15));
      rr  = $urandom_range(1, 3);
      dly = $urandom_range(1, 8);
      start_run(rm, 8'(rr));
      wait_idle(600, 1'b1, idle_at);
      check("rnd_phases", ph_code, model_code(rm, rr));
      check("rnd_starts", starts, $countones(rm) * rr);
      check("rnd_passes", passes_done, rr);
      check("rnd_seq", seq_dones, 1);
      check("rnd_fault", fault, 0);
      check("rnd_seq_after_done", seq_cyc - done_cyc, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Control block that sequences the multi-phase timer through its four phases. For each phase it drives the timer's phase select, issues a start pulse and gates its enable, then waits for the timer's done indication. It supports:
- a per-run phase mask and repeat count,
- pause, abort,
- a per-phase watchdog.

It sits between the system control logic and the timer instance.

## Interface
- `WDOG_MAX`, 1024: enabled cycles allowed per phase before fault (1..65535)
- `clk` in 1: clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `run_req` in 1: single-cycle request to begin a run; ignored while `busy`
- `abort` in 1: terminate run; highest priority after `rst`
- `pause` in 1: level; while high in RUN, `timer_enable` is held low and the watchdog freezes
- `phase_mask` in 4: bit i=1 means phase i executes; latched on accepted `run_req`
- `repeat_cnt` in 8: full passes to run, 0 = continuous; latched on accepted `run_req`
- `timer_done` in 1: done flag from timer, sampled only in RUN
- `timer_phase_sel` out 2: phase select to timer, stable from ARM through RUN
- `timer_start` out 1: one-cycle start pulse to timer
- `timer_enable` out 1: count enable to timer
- `cur_phase` out 2: phase currently executing (= `timer_phase_sel`)
- `passes_done` out 8: completed passes this run, wraps 255→0 in continuous mode
- `busy` out 1: high in any state except IDLE and FAULT
- `seq_done` out 1: one-cycle pulse on normal completion
- `fault` out 1: sticky watchdog fault
- `cfg_err` out 1: one-cycle pulse when `run_req` arrives with `phase_mask`=0

## Operation
- States: IDLE, ARM, RUN, ADVANCE, DONE, FAULT.
- **IDLE**
  - `run_req` with mask≠0: latch mask and repeat, `passes_done`←0, select lowest set mask bit, go to ARM.
  - `run_req` with mask=0: pulse `cfg_err`, stay in IDLE.
- **ARM**
  - `timer_start`=1 and `timer_enable`=0 for exactly one cycle.
  - Watchdog cleared.
  - Then go to RUN.
- **RUN**
  - `timer_enable`=!`pause`.
  - Watchdog increments each cycle with `timer_enable`=1.
  - `timer_done`=1 (regardless of pause) goes to ADVANCE.
  - Otherwise, watchdog reaching `WDOG_MAX` goes to FAULT.
- **ADVANCE** (one cycle, enable=0)
  - Next phase is the lowest set mask bit with index > current phase.
  - If none, wrap to the lowest set bit and increment `passes_done`.
  - If `repeat_cnt`≠0 and the incremented count equals `repeat_cnt`, go to DONE; otherwise go to ARM.
- **DONE**: pulse `seq_done` for one cycle, then IDLE.
- **FAULT**
  - `fault`=1, all timer controls 0.
  - Stays until `run_req`, which clears `fault` and is handled as in IDLE (same cycle).
- **abort**: from any state except FAULT, go to IDLE next cycle. No `seq_done`. `passes_done` holds.
- **Simultaneous events**
  - abort beats `timer_done`.
  - `timer_done` beats watchdog expiry in the same cycle.
  - `run_req` while busy is ignored.
- Mask and repeat changes mid-run have no effect until the next accepted `run_req`.

## Timing
- **Reset values**: state IDLE; `timer_start`, `timer_enable`, `busy`, `seq_done`, `fault`, `cfg_err` all 0; `timer_phase_sel`/`cur_phase` 0; `passes_done` 0.
- All outputs are registered.
- **Latency**: `run_req` at cycle t gives `timer_start`=1 and `busy`=1 at t+1, and `timer_enable`=1 at t+2.
- `timer_done` seen at cycle n gives `timer_enable`=0 at n+1 (ADVANCE) and the next `timer_start` at n+2. Phase-to-phase overhead is 2 cycles.
- On the final phase, `timer_done` at n gives `seq_done` at n+2 and `busy`=0 at n+3.
- Watchdog is 16 bits. FAULT is entered the cycle after the count equals `WDOG_MAX`.
- `rst` mid-run returns to reset values on the next edge. The timer sees `timer_enable` drop in the same cycle.

## Structure
- Shared package `phase_seq_pkg`:
  - state enum,
  - phase index constants `PH0`..`PH3`,
  - default `WDOG_MAX`,
  - function `next_phase(mask, cur)` returning the index and a wrap flag.
- One sub-module, `phase_watchdog`: clear, enable, `WDOG_MAX` compare, expired flag.

## Test plan
- **Full sequence**: mask=4'b1111, repeat=1, `run_req` at t=0; model `timer_done` 5 cycles after each enable.
  - Required: `timer_phase_sel` sequence 0,1,2,3.
  - Required: 4 `timer_start` pulses.
  - Required: `seq_done` 2 cycles after the 4th done.
  - Required: `passes_done`=1.
- **Masked, repeated**: mask=4'b1010, repeat=3.
  - Required: phases 1,3,1,3,1,3.
  - Required: `passes_done` 3.
  - Required: exactly one `seq_done`.
- **Pause**: `pause` high for 10 cycles in RUN.
  - Required: `timer_enable` low for those 10 cycles.
  - Required: the watchdog does not advance.
  - Required: phase completes normally after release.
- **Watchdog**: `WDOG_MAX`=16, `timer_done` never asserted.
  - Required: `fault`=1 on the cycle after the 16th enabled cycle.
  - Required: `busy`=0 and enable 0.
  - Required: a following `run_req` clears `fault` and restarts at phase 0.
- **Abort/done collision**: `abort` and `timer_done` in the same cycle.
  - Required: IDLE next cycle.
  - Required: no ADVANCE, no `seq_done`.
- **Configuration errors**: `run_req` with mask=0 gives a `cfg_err` pulse and stays IDLE; `run_req` while busy leaves the sequence unchanged.
